// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared scan-reader FSM encoding and read-credit helper.
// Revision : 1.0
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  localparam int unsigned c_FIFO_DEPTH = 2;

  // occupancy = FIFO entries plus the read whose data is on ram_rdata now
  function automatic logic read_credit_ok(input logic [1:0] occupancy, input logic pop);
    return ({1'b0, occupancy}) < (3'(c_FIFO_DEPTH) + {2'b00, pop});
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_reader_if
// Brief    : Valid/ready output stream of the RAM scan reader.
// Revision : 1.0
// ============================================================================
interface ram_scan_reader_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface
`default_nettype wire

// File: rtl/scan_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : scan_skid_fifo
// Brief    : 2-entry head/tail buffer; the head register drives the stream.
// Revision : 1.0
// ============================================================================
module scan_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_push_last,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_count
);

  logic                  r_head_v;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic                  r_head_last;
  logic                  r_tail_v;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic                  r_tail_last;
  logic                  w_pop;

  assign w_pop = i_pop & r_head_v;

  // Head only changes when empty or popped, so a stalled beat holds stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_v    <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_v    <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else if (i_flush) begin
      r_head_v <= 1'b0;
      r_tail_v <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_v) begin
        r_head_data <= r_tail_data;
        r_head_last <= r_tail_last;
        r_tail_v    <= i_push;
        r_tail_data <= i_push_data;
        r_tail_last <= i_push_last;
      end else begin
        r_head_v    <= i_push;
        r_head_data <= i_push_data;
        r_head_last <= i_push_last;
      end
    end else if (i_push) begin
      if (!r_head_v) begin
        r_head_v    <= 1'b1;
        r_head_data <= i_push_data;
        r_head_last <= i_push_last;
      end else begin
        r_tail_v    <= 1'b1;
        r_tail_data <= i_push_data;
        r_tail_last <= i_push_last;
      end
    end
  end

  assign o_valid = r_head_v;
  assign o_data  = r_head_data;
  assign o_last  = r_head_last;
  assign o_count = {1'b0, r_head_v} + {1'b0, r_tail_v};

endmodule
`default_nettype wire

// File: rtl/ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_reader
// Brief    : Row-major rectangular scan of a 2-D RAM into a valid/ready stream.
// Revision : 1.0
// ============================================================================
module ram_scan_reader
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH_W = 5,
  parameter int ADDR_WIDTH_H = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH_W-1:0] row_first,
  input  logic [ADDR_WIDTH_W-1:0] row_last,
  input  logic [ADDR_WIDTH_H-1:0] col_first,
  input  logic [ADDR_WIDTH_H-1:0] col_last,
  output logic [ADDR_WIDTH_W-1:0] read_addr_1,
  output logic [ADDR_WIDTH_H-1:0] read_addr_2,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  ram_scan_reader_if.master       strm,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  scan_state_t             r_state;
  logic [ADDR_WIDTH_W-1:0] r_row_first;
  logic [ADDR_WIDTH_W-1:0] r_row_last;
  logic [ADDR_WIDTH_W-1:0] r_row;
  logic [ADDR_WIDTH_H-1:0] r_col_first;
  logic [ADDR_WIDTH_H-1:0] r_col_last;
  logic [ADDR_WIDTH_H-1:0] r_col;
  logic                    r_rd_pend;
  logic                    r_rd_pend_last;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic                    w_fifo_valid;
  logic                    w_fifo_last;
  logic [DATA_WIDTH-1:0]   w_fifo_data;
  logic [1:0]              w_fifo_count;
  logic [1:0]              w_occupancy;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_at_last;
  logic                    w_region_ok;

  // The RAM reads read_addr every cycle; a read counts as issued only in
  // cycles where w_issue is high, otherwise the address simply repeats.
  assign w_pop       = w_fifo_valid & strm.m_ready;
  assign w_occupancy = w_fifo_count + {1'b0, r_rd_pend};
  assign w_issue     = (r_state == SCAN) && read_credit_ok(w_occupancy, w_pop);
  assign w_at_last   = (r_row == r_row_last) && (r_col == r_col_last);
  assign w_region_ok = (row_first <= row_last) && (col_first <= col_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_row_first    <= '0;
      r_row_last     <= '0;
      r_row          <= '0;
      r_col_first    <= '0;
      r_col_last     <= '0;
      r_col          <= '0;
      r_rd_pend      <= 1'b0;
      r_rd_pend_last <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_rd_pend      <= w_issue & ~abort;
      r_rd_pend_last <= w_at_last;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (w_region_ok) begin
                r_row_first <= row_first;
                r_row_last  <= row_last;
                r_col_first <= col_first;
                r_col_last  <= col_last;
                r_row       <= row_first;
                r_col       <= col_first;
                r_state     <= SCAN;
                r_busy      <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          SCAN: begin
            // Counters stop on the last address instead of wrapping.
            if (w_issue) begin
              if (w_at_last) begin
                r_state <= DRAIN;
              end else if (r_col == r_col_last) begin
                r_col <= r_col_first;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (w_pop && w_fifo_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  scan_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (abort),
    .i_push      (r_rd_pend),
    .i_push_data (ram_rdata),
    .i_push_last (r_rd_pend_last),
    .i_pop       (strm.m_ready),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_last      (w_fifo_last),
    .o_count     (w_fifo_count)
  );

  assign strm.m_valid = w_fifo_valid;
  assign strm.m_data  = w_fifo_data;
  assign strm.m_last  = w_fifo_last;
  assign read_addr_1  = r_row;
  assign read_addr_2  = r_col;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_scan_reader
// Brief    : Self-checking bench for ram_scan_reader against a region model.
// Revision : 1.0
// ============================================================================
module tb_ram_scan_reader;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [4:0] row_first, row_last, col_first, col_last;
  logic [4:0] read_addr_1, read_addr_2;
  logic [7:0] ram_rdata;
  logic       busy, done, err;

  logic [7:0] mem [0:31][0:31];

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    model_active = 1'b0;
  bit    exp_done = 1'b0;
  bit    exp_err = 1'b0;
  bit    prev_stall = 1'b0;
  bit    col31_watch = 1'b0;
  int    ready_mode = 0;
  int    rdy_pct = 100;
  int    pat_base = 0;
  int    xfer_cyc[$];
  logic [7:0] xfer_dat[$];
  bit    xfer_lst[$];
  int    done_log[$];
  int    err_log[$];

  ram_scan_reader_if #(.DATA_WIDTH(8)) strm ();

  ram_scan_reader #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH_W (5),
    .ADDR_WIDTH_H (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .row_first   (row_first),
    .row_last    (row_last),
    .col_first   (col_first),
    .col_last    (col_last),
    .read_addr_1 (read_addr_1),
    .read_addr_2 (read_addr_2),
    .ram_rdata   (ram_rdata),
    .strm        (strm),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) ram_rdata <= mem[read_addr_1][read_addr_2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rf, input int rl, input int cf, input int cl, output int c0);
    row_first = 5'(rf);
    row_last  = 5'(rl);
    col_first = 5'(cf);
    col_last  = 5'(cl);
    start     = 1'b1;
    c0        = cyc;
    pat_base  = cyc;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (model_active && n < budget) begin
      step();
      n++;
    end
    if (model_active) begin
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic clear_logs();
    xfer_cyc.delete();
    xfer_dat.delete();
    xfer_lst.delete();
    done_log.delete();
    err_log.delete();
  endtask

  // ready generator runs after the driver within each cycle
  initial begin
    strm.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       strm.m_ready = (((cyc - pat_base) % 4) == 0) || (((cyc - pat_base) % 4) == 3);
        2:       strm.m_ready = ($urandom_range(0, 99) < rdy_pct);
        default: strm.m_ready = 1'b1;
      endcase
    end
  end

  // Reference model and per-cycle comparison
  initial begin
    beat_t f;
    bit    last_xfer;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs", 32'({strm.m_valid, strm.m_last, busy, done, err,
                                    strm.m_data, read_addr_1, read_addr_2}), 32'd0);
        model_active = 1'b0;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        prev_stall   = 1'b0;
        exp_q.delete();
      end else begin
        check("busy", 32'(busy), 32'(model_active));
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(exp_err));
        if (done) done_log.push_back(cyc);
        if (err) err_log.push_back(cyc);
        if (prev_stall) check("hold_valid", 32'(strm.m_valid), 32'd1);
        last_xfer = 1'b0;
        if (strm.m_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", 32'(strm.m_valid), 32'd0);
          end else begin
            f = exp_q[0];
            check("m_data", 32'(strm.m_data), 32'(f.d));
            check("m_last", 32'(strm.m_last), 32'(f.l));
            if (strm.m_ready) begin
              last_xfer = f.l;
              xfer_cyc.push_back(cyc);
              xfer_dat.push_back(strm.m_data);
              xfer_lst.push_back(strm.m_last);
              void'(exp_q.pop_front());
            end
          end
        end
        if (col31_watch && busy) check("col_hold_31", 32'(read_addr_2), 32'd31);
        prev_stall = strm.m_valid && !strm.m_ready && !abort;

        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (abort) begin
          model_active = 1'b0;
          exp_q.delete();
        end else if (!model_active) begin
          if (start) begin
            if (row_first <= row_last && col_first <= col_last) begin
              model_active = 1'b1;
              for (int r = int'(row_first); r <= int'(row_last); r++)
                for (int c = int'(col_first); c <= int'(col_last); c++)
                  exp_q.push_back('{d: mem[r][c], l: (r == int'(row_last) && c == int'(col_last))});
            end else begin
              exp_err = 1'b1;
            end
          end
        end else if (last_xfer) begin
          model_active = 1'b0;
          exp_done     = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [7:0] lit [6];
    logic [4:0] a1, a2;
    int rf, rl, cf, cl, span, n;

    lit[0] = 8'h13; lit[1] = 8'h14; lit[2] = 8'h15;
    lit[3] = 8'h23; lit[4] = 8'h24; lit[5] = 8'h25;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    row_first = '0; row_last = '0; col_first = '0; col_last = '0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        mem[r][c] = 8'(r * 16 + c);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Basic 2x3 region, full throughput
    clear_logs();
    do_start(1, 2, 3, 5, c0);
    wait_idle(50);
    repeat (2) step();
    check("t1_beats", 32'(xfer_dat.size()), 32'd6);
    for (int i = 0; i < 6 && i < xfer_dat.size(); i++) begin
      check("t1_data", 32'(xfer_dat[i]), 32'(lit[i]));
      check("t1_cycle", 32'(xfer_cyc[i] - c0), 32'(3 + i));
      check("t1_last", 32'(xfer_lst[i]), 32'(i == 5));
    end
    check("t1_done_count", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check("t1_done_cycle", 32'(done_log[0] - c0), 32'd9);

    // Same region with 1,0,0,1 ready pattern
    clear_logs();
    ready_mode = 1;
    do_start(1, 2, 3, 5, c0);
    wait_idle(100);
    repeat (2) step();
    ready_mode = 0;
    check("t2_beats", 32'(xfer_dat.size()), 32'd6);
    for (int i = 0; i < 6 && i < xfer_dat.size(); i++)
      check("t2_data", 32'(xfer_dat[i]), 32'(lit[i]));
    check("t2_done_count", 32'(done_log.size()), 32'd1);

    // Empty region request
    clear_logs();
    a1 = read_addr_1;
    a2 = read_addr_2;
    do_start(4, 2, 0, 0, c0);
    check("t3_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("t3_err_count", 32'(err_log.size()), 32'd1);
    if (err_log.size() > 0) check("t3_err_cycle", 32'(err_log[0] - c0), 32'd1);
    check("t3_beats", 32'(xfer_dat.size()), 32'd0);
    check("t3_addr", 32'({read_addr_1, read_addr_2}), 32'({a1, a2}));

    // Full-height single column at the top address
    clear_logs();
    col31_watch = 1'b1;
    do_start(0, 31, 31, 31, c0);
    wait_idle(100);
    repeat (2) step();
    col31_watch = 1'b0;
    check("t4_beats", 32'(xfer_dat.size()), 32'd32);
    if (xfer_cyc.size() == 32) check("t4_last_cycle", 32'(xfer_cyc[31] - c0), 32'd34);
    if (done_log.size() > 0) check("t4_done_cycle", 32'(done_log[0] - c0), 32'd35);
    check("t4_final_addr", 32'({read_addr_1, read_addr_2}), 32'({5'd31, 5'd31}));

    // Abort on the second beat, then rescan
    clear_logs();
    do_start(1, 2, 3, 5, c0);
    while (cyc < c0 + 4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    #3;
    check("t5_valid_low", 32'(strm.m_valid), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    repeat (6) step();
    check("t5_beats", 32'(xfer_dat.size()), 32'd2);
    check("t5_no_done", 32'(done_log.size()), 32'd0);
    clear_logs();
    do_start(1, 2, 3, 5, c0);
    wait_idle(50);
    repeat (2) step();
    check("t5_rescan_beats", 32'(xfer_dat.size()), 32'd6);
    if (xfer_dat.size() == 6) check("t5_rescan_last", 32'(xfer_dat[5]), 32'h25);

    // Asynchronous reset mid-scan
    do_start(0, 3, 0, 7, c0);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'({strm.m_valid, strm.m_last, busy, done, err,
                                 strm.m_data, read_addr_1, read_addr_2}), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    clear_logs();
    repeat (12) step();
    check("t6_no_beats", 32'(xfer_dat.size()), 32'd0);
    check("t6_idle", 32'({busy, done}), 32'd0);

    // Randomised regions, ready patterns, aborts and ignored starts
    for (int s = 0; s < 40; s++) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          mem[r][c] = 8'($urandom);
      rf = $urandom_range(0, 31);
      span = 31 - rf;
      if (span > 6) span = 6;
      rl = rf + $urandom_range(0, span);
      if ($urandom_range(0, 9) == 0 && rf > 0) rl = $urandom_range(0, rf - 1);
      cf = $urandom_range(0, 31);
      span = 31 - cf;
      if (span > 6) span = 6;
      cl = cf + $urandom_range(0, span);
      if ($urandom_range(0, 9) == 0 && cf > 0) cl = $urandom_range(0, cf - 1);
      case ($urandom_range(0, 3))
        0:       rdy_pct = 100;
        1:       rdy_pct = 70;
        2:       rdy_pct = 40;
        default: rdy_pct = 15;
      endcase
      ready_mode = 2;
      do_start(rf, rl, cf, cl, c0);
      n = 0;
      while (model_active && n < 3000) begin
        abort = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 15) == 0) begin
          start     = 1'b1;
          row_first = 5'($urandom);
          row_last  = 5'($urandom);
          col_first = 5'($urandom);
          col_last  = 5'($urandom);
        end
        step();
        start = 1'b0;
        abort = 1'b0;
        n++;
      end
      if (model_active) begin
        errors++;
        $display("FAIL scan_timeout: scan %0d still busy, required idle", s);
      end
      repeat (2) step();
    end
    ready_mode = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_scan_reader.md
RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the RAM word and stream data width.
REQ-002 Parameter ADDR_WIDTH_W, default 5, SHALL set the row address width.
REQ-003 Parameter ADDR_WIDTH_H, default 5, SHALL set the column address width.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, as listed below.
REQ-005 clk  in  1  rising-edge clock shared with the 2-D dual-port RAM.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to scan a region; sampled in IDLE only.
REQ-008 abort  in  1  terminates an active scan.
REQ-009 row_first, row_last  in  ADDR_WIDTH_W each  inclusive row bounds; sampled on accepted start.
REQ-010 col_first, col_last  in  ADDR_WIDTH_H each  inclusive column bounds; sampled on accepted start.
REQ-011 read_addr_1  out  ADDR_WIDTH_W  registered row address to RAM.
REQ-012 read_addr_2  out  ADDR_WIDTH_H  registered column address to RAM.
REQ-013 ram_rdata  in  DATA_WIDTH  RAM registered read data; valid one cycle after the address cycle.
REQ-014 m_data  out  DATA_WIDTH  stream data.
REQ-015 m_valid  out  1  stream data valid.
REQ-016 m_ready  in  1  downstream accept; a beat transfers when m_valid and m_ready are both high.
REQ-017 m_last  out  1  marks the final beat of a region.
REQ-018 busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-019 done  out  1  one-cycle pulse on normal completion.
REQ-020 err  out  1  one-cycle pulse on an empty-region request.

Function
REQ-021 The FSM SHALL have states IDLE, SCAN (issuing reads) and DRAIN (no reads left, buffer non-empty).
- IDLE->SCAN on start with a valid region.
- SCAN->DRAIN after the last address is issued.
- DRAIN->IDLE when the m_last beat transfers.
REQ-022 Scan order SHALL be row-major: the column increments to col_last, then wraps to col_first while the row increments.
REQ-023 Address counters SHALL compare against the last bounds and never overflow; row/col value 2^W-1 SHALL be legal.
REQ-024 Read data SHALL pass through a 2-entry FIFO.
- A read is issued only when occupancy + in-flight reads - pops this cycle < 2.
- No beat is ever dropped or duplicated under any m_ready pattern.
REQ-025 With m_ready held high, throughput SHALL be one beat per cycle.
REQ-026 Latency SHALL be fixed:
- start accepted at cycle 0.
- First address driven in cycle 1.
- ram_rdata captured at the end of cycle 2.
- m_valid high in cycle 3.
REQ-027 Once m_valid is high, m_data, m_valid and m_last SHALL hold stable until the beat transfers.
REQ-028 done SHALL pulse in the cycle after the m_last transfer; busy SHALL fall in that same cycle.
REQ-029 If row_first>row_last or col_first>col_last at start, the block SHALL stay in IDLE, issue no reads and no beats, and pulse err the next cycle.
REQ-030 start SHALL be ignored while busy.
REQ-031 abort SHALL take effect the next cycle:
- Returns to IDLE and flushes the FIFO.
- Discards in-flight data.
- Drives m_valid low.
- No done pulse.
REQ-032 If abort and start occur in the same cycle, abort SHALL win.
REQ-033 Beat count SHALL equal (row_last-row_first+1)*(col_last-col_first+1).

Reset
REQ-034 Asserting rst_n low SHALL immediately force IDLE and empty the FIFO.
REQ-035 During reset, the following outputs SHALL be 0: m_valid, m_last, busy, done, err, m_data, read_addr_1, read_addr_2.
REQ-036 Reset released mid-scan SHALL leave the block idle, with no residual beats.

Structure
REQ-037 FSM state encoding SHALL reside in the shared package mem_pkg.
REQ-038 The 2-entry output buffer SHALL be sub-module scan_skid_fifo.

Verification
REQ-039 Region rows 1..2, cols 3..5, RAM[r][c]=r*16+c, m_ready=1 -> six beats 0x13,0x14,0x15,0x23,0x24,0x25 in cycles 3..8; m_last on 0x25; done in cycle 9.
REQ-040 Same region, m_ready toggling 1,0,0,1 repeating -> identical six-beat sequence, no loss or repeat, data stable while stalled.
REQ-041 row_first=4, row_last=2 -> no reads, no beats, err pulse in cycle 1, busy stays 0.
REQ-042 Region 0..31 x 31..31 -> 32 beats with read_addr_2=31 throughout; no counter wrap past 31.
REQ-043 abort on the second beat -> m_valid low the next cycle, busy 0, no done; a new start then scans correctly.
REQ-044 rst_n pulsed low mid-scan -> all outputs 0 asynchronously; no beats after release.
